// File: rtl/adr_pkg.sv
// Shared types and constants for the ADR execute stage.
package adr_pkg;

  typedef enum logic [4:0] {
    FN_NOP  = 5'd0,
    FN_ADD  = 5'd1,
    FN_SUB  = 5'd2,
    FN_AND  = 5'd3,
    FN_OR   = 5'd4,
    FN_XOR  = 5'd5,
    FN_SLL  = 5'd6,
    FN_SRL  = 5'd7,
    FN_SRA  = 5'd8,
    FN_SLT  = 5'd9,
    FN_SLTU = 5'd10,
    FN_LUI  = 5'd11,
    FN_BEQ  = 5'd12,
    FN_BNE  = 5'd13,
    FN_BLT  = 5'd14,
    FN_BGE  = 5'd15,
    FN_BLTU = 5'd16,
    FN_BGEU = 5'd17,
    FN_JAL  = 5'd18,
    FN_JALR = 5'd19,
    FN_MUL  = 5'd20
  } adr_fn_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } adr_state_e;

  localparam int unsigned OPT_IMM_BIT = 5;
  localparam int unsigned PC_INC      = 4;

endpackage

// File: rtl/adr_mul_iter.sv
// Shift-add multiplier: one multiplier bit per cycle, low XLEN bits of a*b.
module adr_mul_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done_c,
  output logic [XLEN-1:0] product_c
);

  localparam int unsigned CW = $clog2(XLEN);

  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] partial;

  assign partial   = mplier[0] ? mcand : '0;
  // product_c already includes the current bit, so it is final on the done cycle
  assign product_c = acc + partial;
  assign done_c    = busy && (cnt == CW'(XLEN - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (busy) begin
      acc    <= product_c;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done_c) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/adr_execute.sv
// ADR execute stage: ALU, branch resolution, iterative MUL, writeback and
// redirect registers, and wrong-path squash after a redirect.
module adr_execute
  import adr_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned PC_LEN       = 32,
  parameter int unsigned SQUASH_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              de_ex_valid_i,
  input  logic [5:0]        de_ex_optype_i,
  input  logic [XLEN-1:0]   de_ex_data_a_i,
  input  logic [XLEN-1:0]   de_ex_data_b_i,
  input  logic [XLEN-1:0]   de_ex_data_imm_i,
  input  logic [PC_LEN-1:0] de_ex_pc_i,
  input  logic [4:0]        de_ex_rd_i,
  output logic              ex_de_stall_o,
  output logic              ex_if_redirect_o,
  output logic [PC_LEN-1:0] ex_if_target_o,
  output logic              ex_wb_valid_o,
  output logic [4:0]        ex_wb_addr_o,
  output logic [XLEN-1:0]   ex_wb_data_o
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned SQW = (SQUASH_DEPTH < 1) ? 1 : $clog2(SQUASH_DEPTH + 1);

  adr_state_e      state, state_n;
  logic [SQW-1:0]  sq_cnt, sq_cnt_n;
  logic [4:0]      mul_rd, mul_rd_n;
  logic            wb_valid_n, redirect_n;
  logic [4:0]      wb_addr_n;
  logic [XLEN-1:0] wb_data_n;
  logic [PC_LEN-1:0] target_n;

  adr_fn_e         fn;
  logic            use_imm, accept, mul_start;
  logic            mul_busy, mul_done_c;
  logic [XLEN-1:0] mul_product_c;
  logic [XLEN-1:0] opb, alu_res, jalr_sum;
  logic [SHW-1:0]  shamt;
  logic            taken;
  logic [PC_LEN-1:0] br_target, link_pc;

  assign fn      = adr_fn_e'(de_ex_optype_i[4:0]);
  assign use_imm = de_ex_optype_i[OPT_IMM_BIT] && (fn >= FN_ADD) && (fn <= FN_SLTU);
  assign opb     = use_imm ? de_ex_data_imm_i : de_ex_data_b_i;
  assign shamt   = opb[SHW-1:0];
  assign accept  = de_ex_valid_i && (state == ST_IDLE) && (sq_cnt == '0);

  assign ex_de_stall_o = (state == ST_MUL);

  assign br_target = de_ex_pc_i + PC_LEN'(de_ex_data_imm_i);
  assign link_pc   = de_ex_pc_i + PC_LEN'(PC_INC);
  assign jalr_sum  = de_ex_data_a_i + de_ex_data_imm_i;

  // ALU result for function codes 1-11
  always_comb begin
    alu_res = '0;
    case (fn)
      FN_ADD:  alu_res = de_ex_data_a_i + opb;
      FN_SUB:  alu_res = de_ex_data_a_i - opb;
      FN_AND:  alu_res = de_ex_data_a_i & opb;
      FN_OR:   alu_res = de_ex_data_a_i | opb;
      FN_XOR:  alu_res = de_ex_data_a_i ^ opb;
      FN_SLL:  alu_res = de_ex_data_a_i << shamt;
      FN_SRL:  alu_res = de_ex_data_a_i >> shamt;
      FN_SRA:  alu_res = $unsigned($signed(de_ex_data_a_i) >>> shamt);
      FN_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(de_ex_data_a_i) < $signed(opb)};
      FN_SLTU: alu_res = {{(XLEN-1){1'b0}}, de_ex_data_a_i < opb};
      FN_LUI:  alu_res = de_ex_data_imm_i;
      default: alu_res = '0;
    endcase
  end

  // Branch condition always compares a against data_b
  always_comb begin
    taken = 1'b0;
    case (fn)
      FN_BEQ:  taken = de_ex_data_a_i == de_ex_data_b_i;
      FN_BNE:  taken = de_ex_data_a_i != de_ex_data_b_i;
      FN_BLT:  taken = $signed(de_ex_data_a_i) <  $signed(de_ex_data_b_i);
      FN_BGE:  taken = $signed(de_ex_data_a_i) >= $signed(de_ex_data_b_i);
      FN_BLTU: taken = de_ex_data_a_i <  de_ex_data_b_i;
      FN_BGEU: taken = de_ex_data_a_i >= de_ex_data_b_i;
      default: taken = 1'b0;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_n    = state;
    sq_cnt_n   = sq_cnt;
    mul_rd_n   = mul_rd;
    mul_start  = 1'b0;
    wb_valid_n = 1'b0;
    wb_addr_n  = ex_wb_addr_o;
    wb_data_n  = ex_wb_data_o;
    redirect_n = 1'b0;
    target_n   = ex_if_target_o;

    if (accept) begin
      case (fn)
        FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_SLL, FN_SRL, FN_SRA,
        FN_SLT, FN_SLTU, FN_LUI: begin
          wb_valid_n = (de_ex_rd_i != 5'd0);
          wb_addr_n  = de_ex_rd_i;
          wb_data_n  = alu_res;
        end
        FN_BEQ, FN_BNE, FN_BLT, FN_BGE, FN_BLTU, FN_BGEU: begin
          if (taken) begin
            redirect_n = 1'b1;
            target_n   = br_target;
            sq_cnt_n   = SQW'(SQUASH_DEPTH);
          end
        end
        FN_JAL, FN_JALR: begin
          redirect_n = 1'b1;
          target_n   = (fn == FN_JAL) ? br_target
                                      : (PC_LEN'(jalr_sum) & ~PC_LEN'(1));
          sq_cnt_n   = SQW'(SQUASH_DEPTH);
          wb_valid_n = (de_ex_rd_i != 5'd0);
          wb_addr_n  = de_ex_rd_i;
          wb_data_n  = XLEN'(link_pc);
        end
        FN_MUL: begin
          mul_start = 1'b1;
          mul_rd_n  = de_ex_rd_i;
          state_n   = ST_MUL;
        end
        default: ;
      endcase
    end else if (de_ex_valid_i && (state == ST_IDLE) && (sq_cnt != '0)) begin
      sq_cnt_n = sq_cnt - SQW'(1);
    end

    if (state == ST_MUL && (mul_done_c || !mul_busy)) begin
      state_n    = ST_IDLE;
      wb_valid_n = mul_done_c && (mul_rd != 5'd0);
      wb_addr_n  = mul_rd;
      wb_data_n  = mul_product_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      sq_cnt           <= '0;
      mul_rd           <= '0;
      ex_wb_valid_o    <= 1'b0;
      ex_wb_addr_o     <= '0;
      ex_wb_data_o     <= '0;
      ex_if_redirect_o <= 1'b0;
      ex_if_target_o   <= '0;
    end else begin
      state            <= state_n;
      sq_cnt           <= sq_cnt_n;
      mul_rd           <= mul_rd_n;
      ex_wb_valid_o    <= wb_valid_n;
      ex_wb_addr_o     <= wb_addr_n;
      ex_wb_data_o     <= wb_data_n;
      ex_if_redirect_o <= redirect_n;
      ex_if_target_o   <= target_n;
    end
  end

  adr_mul_iter #(.XLEN(XLEN)) u_mul (
    .clk       (clk),
    .reset     (reset),
    .start     (mul_start),
    .a         (de_ex_data_a_i),
    .b         (de_ex_data_b_i),
    .busy      (mul_busy),
    .done_c    (mul_done_c),
    .product_c (mul_product_c)
  );

endmodule

// File: tb/tb_adr_execute.sv
// Scoreboard bench for adr_execute: directed vectors, expected wb/redirect queued at issue.
module tb_adr_execute;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        de_ex_valid_i = 1'b0;
  logic [5:0]  de_ex_optype_i = '0;
  logic [31:0] de_ex_data_a_i = '0;
  logic [31:0] de_ex_data_b_i = '0;
  logic [31:0] de_ex_data_imm_i = '0;
  logic [31:0] de_ex_pc_i = '0;
  logic [4:0]  de_ex_rd_i = '0;
  logic        ex_de_stall_o;
  logic        ex_if_redirect_o;
  logic [31:0] ex_if_target_o;
  logic        ex_wb_valid_o;
  logic [4:0]  ex_wb_addr_o;
  logic [31:0] ex_wb_data_o;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_exp_t;

  wb_exp_t     wb_q[$];
  logic [31:0] tgt_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  adr_execute dut (
    .clk              (clk),
    .reset            (reset),
    .de_ex_valid_i    (de_ex_valid_i),
    .de_ex_optype_i   (de_ex_optype_i),
    .de_ex_data_a_i   (de_ex_data_a_i),
    .de_ex_data_b_i   (de_ex_data_b_i),
    .de_ex_data_imm_i (de_ex_data_imm_i),
    .de_ex_pc_i       (de_ex_pc_i),
    .de_ex_rd_i       (de_ex_rd_i),
    .ex_de_stall_o    (ex_de_stall_o),
    .ex_if_redirect_o (ex_if_redirect_o),
    .ex_if_target_o   (ex_if_target_o),
    .ex_wb_valid_o    (ex_wb_valid_o),
    .ex_wb_addr_o     (ex_wb_addr_o),
    .ex_wb_data_o     (ex_wb_data_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents wb or redirect
  always @(negedge clk) begin
    if (!reset) begin
      if (ex_wb_valid_o) begin
        if (wb_q.size() == 0) begin
          check("wb_unexpected", {27'd0, ex_wb_addr_o}, 32'hFFFF_FFFF);
        end else begin
          wb_exp_t e;
          e = wb_q.pop_front();
          check("wb_addr", {27'd0, ex_wb_addr_o}, {27'd0, e.addr});
          check("wb_data", ex_wb_data_o, e.data);
        end
      end
      if (ex_if_redirect_o) begin
        if (tgt_q.size() == 0) check("redirect_unexpected", ex_if_target_o, 32'hFFFF_FFFF);
        else check("redirect_target", ex_if_target_o, tgt_q.pop_front());
      end
    end
  end

  task automatic push_wb(input logic [4:0] addr, input logic [31:0] data);
    wb_exp_t e;
    e.addr = addr;
    e.data = data;
    wb_q.push_back(e);
  endtask

  // Present one instruction and hold it until the edge that samples stall low
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd,
                       output int stalls);
    de_ex_optype_i   = op;
    de_ex_data_a_i   = a;
    de_ex_data_b_i   = b;
    de_ex_data_imm_i = imm;
    de_ex_pc_i       = pc;
    de_ex_rd_i       = rd;
    de_ex_valid_i    = 1'b1;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!ex_de_stall_o) break;
      stalls++;
      if (stalls > 100) begin
        check("stall_timeout", 32'(stalls), 32'd32);
        break;
      end
    end
    @(posedge clk);
    #1;
    de_ex_valid_i = 1'b0;
  endtask

  task automatic squash2();
    int s;
    issue(6'd1, 32'd1, 32'd1, 32'd0, 32'd0, 5'd9, s);
    issue(6'd1, 32'd2, 32'd2, 32'd0, 32'd0, 5'd9, s);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_stall"}, {31'd0, ex_de_stall_o}, 32'd0);
    check({name, "_redirect"}, {31'd0, ex_if_redirect_o}, 32'd0);
    check({name, "_target"}, ex_if_target_o, 32'd0);
    check({name, "_wb_valid"}, {31'd0, ex_wb_valid_o}, 32'd0);
    check({name, "_wb_addr"}, {27'd0, ex_wb_addr_o}, 32'd0);
    check({name, "_wb_data"}, ex_wb_data_o, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // ADD, then wb must drop the following cycle
    push_wb(5'd3, 32'd12);
    issue(6'd1, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3, s);
    @(negedge clk);
    check("add_wb_pulse", {31'd0, ex_wb_valid_o}, 32'd1);
    @(negedge clk);
    check("add_wb_drop", {31'd0, ex_wb_valid_o}, 32'd0);
    @(posedge clk);
    #1;

    // ALU vectors
    push_wb(5'd6, 32'hF800_0000);
    issue(6'h28, 32'h8000_0000, 32'd0, 32'd4, 32'd0, 5'd6, s);
    push_wb(5'd7, 32'd1);
    issue(6'd10, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd7, s);
    push_wb(5'd8, 32'd0);
    issue(6'd9, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd8, s);
    push_wb(5'd11, 32'hFFFF_FFFE);
    issue(6'd2, 32'd5, 32'd7, 32'd0, 32'd0, 5'd11, s);
    push_wb(5'd12, 32'h0FF0_0FF0);
    issue(6'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'd0, 5'd12, s);
    push_wb(5'd13, 32'hF000_F000);
    issue(6'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'd0, 5'd13, s);
    push_wb(5'd14, 32'hFFF0_FFF0);
    issue(6'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'd0, 5'd14, s);
    push_wb(5'd15, 32'h8000_0000);
    issue(6'h26, 32'd1, 32'd0, 32'd31, 32'd0, 5'd15, s);
    push_wb(5'd16, 32'h0800_0000);
    issue(6'd7, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 5'd16, s);
    push_wb(5'd17, 32'd7);
    issue(6'h21, 32'd10, 32'd99, 32'hFFFF_FFFD, 32'd0, 5'd17, s);
    push_wb(5'd10, 32'hABCD_0000);
    issue(6'd11, 32'd0, 32'd0, 32'hABCD_0000, 32'd0, 5'd10, s);
    issue(6'd1, 32'd5, 32'd7, 32'd0, 32'd0, 5'd0, s);   // rd=0: no wb
    issue(6'd0, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3, s);   // NOP
    issue(6'd25, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3, s);  // illegal code

    // Branches: taken ones squash the next two valid inputs
    tgt_q.push_back(32'h0000_0120);
    issue(6'd12, 32'd9, 32'd9, 32'h20, 32'h100, 5'd1, s);
    issue(6'd1, 32'd1, 32'd2, 32'd0, 32'd0, 5'd4, s);
    issue(6'd1, 32'd1, 32'd2, 32'd0, 32'd0, 5'd4, s);
    push_wb(5'd4, 32'd3);
    issue(6'd1, 32'd1, 32'd2, 32'd0, 32'd0, 5'd4, s);
    issue(6'd13, 32'd9, 32'd9, 32'h20, 32'h100, 5'd1, s); // BNE not taken
    tgt_q.push_back(32'h0000_01F8);
    issue(6'd14, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 32'h200, 5'd1, s);
    squash2();
    issue(6'd16, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h200, 5'd1, s); // BLTU not taken
    tgt_q.push_back(32'h0000_0310);
    issue(6'd15, 32'd1, 32'hFFFF_FFFF, 32'h10, 32'h300, 5'd1, s);
    squash2();
    issue(6'd17, 32'd1, 32'hFFFF_FFFF, 32'h10, 32'h300, 5'd1, s); // BGEU not taken

    // Jumps
    tgt_q.push_back(32'h0000_1000);
    push_wb(5'd1, 32'h0000_0044);
    issue(6'd19, 32'h1001, 32'd0, 32'd0, 32'h40, 5'd1, s);
    squash2();
    tgt_q.push_back(32'h0000_1000);
    issue(6'd19, 32'h1001, 32'd0, 32'd0, 32'h40, 5'd0, s);
    squash2();
    tgt_q.push_back(32'h0000_0004);
    push_wb(5'd2, 32'h0000_0000);
    issue(6'd18, 32'd0, 32'd0, 32'd8, 32'hFFFF_FFFC, 5'd2, s);
    squash2();

    // MUL with a held ADD behind it
    push_wb(5'd5, 32'hFFFF_FFFD);
    issue(6'd20, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'd0, 5'd5, s);
    push_wb(5'd18, 32'd30);
    issue(6'd1, 32'd10, 32'd20, 32'd0, 32'd0, 5'd18, s);
    check("mul_stall_cycles", 32'(s), 32'd32);
    repeat (3) @(negedge clk);

    // Reset in the middle of a MUL: no writeback may appear
    @(posedge clk);
    #1;
    issue(6'd20, 32'd7, 32'd6, 32'd0, 32'd0, 5'd19, s);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("mul_reset");
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("post_reset_stall", {31'd0, ex_de_stall_o}, 32'd0);
    @(posedge clk);
    #1;
    push_wb(5'd20, 32'd9);
    issue(6'd1, 32'd4, 32'd5, 32'd0, 32'd0, 5'd20, s);
    repeat (4) @(negedge clk);

    check("wb_queue_drained", 32'(wb_q.size()), 32'd0);
    check("redirect_queue_drained", 32'(tgt_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
